// File: rtl/writeback_buffer_pkg.sv
// Shared types and constants for the write-back buffer and its drain FSM.
package writeback_buffer_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int BLOCK_WORDS  = 4;
    localparam int BLOCK_ADDR_W = 14;

    // One buffered victim block.
    typedef struct packed {
        logic                                  valid;
        logic [BLOCK_ADDR_W-1:0]               addr;
        logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] data;
    } wb_entry_t;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WRITE
    } drain_state_t;

endpackage

// File: rtl/wb_drain_fsm.sv
// Drain sequencer: waits the memory access latency, then writes the head
// block one word per cycle and signals retirement on the last word.
module wb_drain_fsm #(
    parameter int LATENCY = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pending,
    input  logic       morePending,
    output logic       memWrite,
    output logic [1:0] wordIdx,
    output logic       retire,
    output logic       idle
);
    import writeback_buffer_pkg::*;

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [1:0] LAST_WORD = 2'(BLOCK_WORDS - 1);

    drain_state_t     state;
    drain_state_t     stateNext;
    logic [LAT_W-1:0] latCnt;
    logic [LAT_W-1:0] latCntNext;
    logic [1:0]       wordIdxNext;

    // State, latency counter and word index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            latCnt  <= '0;
            wordIdx <= '0;
        end else begin
            state   <= stateNext;
            latCnt  <= latCntNext;
            wordIdx <= wordIdxNext;
        end
    end

    // Next-state logic; after the last word go straight back to WAIT when
    // more blocks are queued so back-to-back blocks see no IDLE cycle.
    always_comb begin
        stateNext   = state;
        latCntNext  = latCnt;
        wordIdxNext = wordIdx;
        case (state)
            IDLE: begin
                if (pending) begin
                    stateNext  = WAIT;
                    latCntNext = LAT_LOAD;
                end
            end
            WAIT: begin
                if (latCnt == '0) begin
                    stateNext   = WRITE;
                    wordIdxNext = '0;
                end else begin
                    latCntNext = latCnt - 1'b1;
                end
            end
            WRITE: begin
                wordIdxNext = wordIdx + 1'b1;
                if (wordIdx == LAST_WORD) begin
                    if (morePending) begin
                        stateNext  = WAIT;
                        latCntNext = LAT_LOAD;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign memWrite = (state == WRITE);
    assign retire   = (state == WRITE) && (wordIdx == LAST_WORD);
    assign idle     = (state == IDLE);

endmodule

// File: rtl/writeback_buffer.sv
// Block write-back buffer: circular FIFO of victim blocks, youngest-wins
// snoop for refills, and a drain path writing one word per cycle to memory.
module writeback_buffer #(
    parameter int DEPTH     = 2,
    parameter int LATENCY   = 7,
    parameter int WORD_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [13:0]            wb_addr,
    input  logic [4*WORD_SIZE-1:0] wb_data,
    input  logic [13:0]            lookup_addr,
    output logic                   lookup_hit,
    output logic [4*WORD_SIZE-1:0] lookup_data,
    output logic                   mem_write,
    output logic [WORD_SIZE-1:0]   mem_address,
    output logic [WORD_SIZE-1:0]   mem_data,
    output logic                   empty
);
    import writeback_buffer_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] snoopIdx;
    logic             enq;
    logic             retire;
    logic             fsmIdle;
    logic             memWrite;
    logic [1:0]       wordIdx;
    wb_entry_t        headEntry;

    assign wb_ready  = (count < CNT_W'(DEPTH)) || retire;
    assign enq       = wb_valid && wb_ready;
    assign headEntry = entries[head];

    wb_drain_fsm #(
        .LATENCY(LATENCY)
    ) drainFsm (
        .clk        (clk),
        .reset      (reset),
        .pending    (count != '0),
        .morePending((count > CNT_W'(1)) || enq),
        .memWrite   (memWrite),
        .wordIdx    (wordIdx),
        .retire     (retire),
        .idle       (fsmIdle)
    );

    // FIFO storage and pointers; an enqueue into the retiring slot (full
    // buffer) is written after the valid clear so the new block wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (enq) begin
                entries[tail].valid <= 1'b1;
                entries[tail].addr  <= wb_addr;
                entries[tail].data  <= wb_data;
                tail                <= tail + 1'b1;
            end
            case ({enq, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Snoop from oldest to youngest so the youngest matching entry wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        snoopIdx    = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            snoopIdx = head + PTR_W'(i);
            if (entries[snoopIdx].valid && (entries[snoopIdx].addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = entries[snoopIdx].data;
            end
        end
    end

    assign mem_write   = memWrite;
    assign mem_address = memWrite ? WORD_SIZE'({headEntry.addr, wordIdx}) : '0;
    assign mem_data    = memWrite ? headEntry.data[wordIdx] : '0;
    assign empty       = (count == '0) && fsmIdle;

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer: directed scenarios plus random
// traffic, checked against a block-level timing/ordering model.
module tb_writeback_buffer;

    localparam int DEPTH   = 2;
    localparam int LATENCY = 7;
    localparam int WS      = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [13:0]   wb_addr = '0;
    logic [63:0]   wb_data = '0;
    logic [13:0]   lookup_addr = '0;
    logic          lookup_hit;
    logic [63:0]   lookup_data;
    logic          mem_write;
    logic [15:0]   mem_address;
    logic [15:0]   mem_data;
    logic          empty;

    writeback_buffer #(
        .DEPTH(DEPTH),
        .LATENCY(LATENCY),
        .WORD_SIZE(WS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .lookup_addr(lookup_addr),
        .lookup_hit (lookup_hit),
        .lookup_data(lookup_data),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] addr;
        logic [63:0] data;
        int          enqEdge;
        int          first;
    } blk_t;

    typedef struct {
        int          cycle;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    blk_t        blocks[$];
    wr_t         expWrites[$];
    int          lastWrite = -100;
    logic [15:0] memImg [int];
    int          checks = 0;
    int          errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // A block waits for the previous one to retire; otherwise it starts
    // its latency the cycle after it is seen.
    function automatic void modelEnqueue(logic [13:0] a, logic [63:0] d, int t);
        blk_t b;
        wr_t  w;
        b.addr    = a;
        b.data    = d;
        b.enqEdge = t;
        b.first   = (t <= lastWrite + 1) ? lastWrite + 1 + LATENCY : t + 1 + LATENCY;
        lastWrite = b.first + 3;
        blocks.push_back(b);
        for (int i = 0; i < 4; i++) begin
            w.cycle = b.first + i;
            w.addr  = {a, 2'(i)};
            w.data  = d[16*i +: 16];
            expWrites.push_back(w);
        end
    endfunction

    function automatic void modelReset();
        blocks.delete();
        expWrites.delete();
        lastWrite = -100;
    endfunction

    function automatic bit isPresent(blk_t b, int c);
        return (b.enqEdge <= c) && (c < b.first + 4);
    endfunction

    // Monitor: compares every cycle against the model and pops the
    // expected-write queue whenever the DUT strobes memory.
    always @(negedge clk) begin : monitor
        int          n;
        bit          retiring;
        bit          hit;
        logic [63:0] sdata;
        wr_t         w;
        n = 0;
        retiring = 0;
        hit = 0;
        sdata = '0;
        foreach (blocks[i]) begin
            if (isPresent(blocks[i], cyc)) begin
                n++;
                if (blocks[i].first + 3 == cyc) retiring = 1;
                if (blocks[i].addr == lookup_addr) begin
                    hit = 1;
                    sdata = blocks[i].data;
                end
            end
        end
        check("wb_ready", wb_ready, (n < DEPTH) || retiring);
        check("empty", empty, n == 0);
        check("lookup_hit", lookup_hit, hit);
        check("lookup_data", lookup_data, sdata);
        if (mem_write) begin
            memImg[int'(mem_address)] = mem_data;
            if (expWrites.size() == 0) begin
                check("unexpected_write", mem_address, 64'hFFFF_FFFF);
            end else begin
                w = expWrites.pop_front();
                check("write_cycle", cyc, w.cycle);
                check("write_addr", mem_address, w.addr);
                check("write_data", mem_data, w.data);
            end
        end else begin
            check("idle_mem_address", mem_address, 0);
            check("idle_mem_data", mem_data, 0);
            if (expWrites.size() > 0 && expWrites[0].cycle <= cyc) begin
                w = expWrites.pop_front();
                check("missing_write", w.cycle, 64'hFFFF_FFFF);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) step();
    endtask

    task automatic offer(input logic [13:0] a, input logic [63:0] d, output int edgeT);
        int waited;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        waited   = 0;
        while (!wb_ready && waited < 40) begin
            step();
            waited++;
        end
        if (!wb_ready) begin
            check("offer_timeout", waited, 0);
            wb_valid = 1'b0;
            edgeT = -1;
        end else begin
            edgeT = cyc + 1;
            modelEnqueue(a, d, edgeT);
            step();
            wb_valid = 1'b0;
        end
    endtask

    task automatic waitEmpty(output int c);
        int k;
        k = 0;
        while (!empty && k < 100) begin
            step();
            k++;
        end
        if (!empty) check("empty_timeout", k, 0);
        c = cyc;
    endtask

    function automatic logic [15:0] memAt(int a);
        return memImg.exists(a) ? memImg[a] : 16'hDEAD;
    endfunction

    initial begin : stimulus
        int t0, t1, t2, t3, found, ec;
        logic [63:0] rd;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_ready", wb_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_lookup_hit", lookup_hit, 0);
        check("rst_lookup_data", lookup_data, 0);
        #1 reset = 1'b0;
        step();

        // Single block latency.
        offer(14'h00A, {16'd4, 16'd3, 16'd2, 16'd1}, t0);
        found = -1;
        for (int k = 0; k < 30 && found < 0; k++) begin
            if (mem_write) found = cyc;
            else step();
        end
        check("t1_first_write_cycle", found, t0 + LATENCY + 1);
        check("t1_first_addr", mem_address, 16'h0028);
        check("t1_first_data", mem_data, 16'd1);
        waitEmpty(ec);
        check("t1_empty_cycle", ec, t0 + LATENCY + 5);

        // Full buffer: third block accepted on the head's retire.
        offer(14'h001, {$urandom, $urandom}, t1);
        offer(14'h002, {$urandom, $urandom}, t2);
        check("t2_second_accept", t2, t1 + 1);
        check("t2_ready_full", wb_ready, 0);
        offer(14'h003, {$urandom, $urandom}, t3);
        check("t2_third_accept", t3, t1 + LATENCY + 5);
        waitEmpty(ec);

        // Snoop during WAIT, during word 2, and after retire.
        offer(14'h005, {16'hD, 16'hC, 16'hB, 16'hA}, t0);
        lookup_addr = 14'h005;
        waitUntil(t0 + 3);
        check("t3_wait_hit", lookup_hit, 1);
        check("t3_wait_data", lookup_data, {16'hD, 16'hC, 16'hB, 16'hA});
        waitUntil(t0 + LATENCY + 3);
        check("t3_word2_strobe", mem_address, 16'h0016);
        check("t3_word2_hit", lookup_hit, 1);
        check("t3_word2_data", lookup_data, {16'hD, 16'hC, 16'hB, 16'hA});
        waitUntil(t0 + LATENCY + 5);
        check("t3_after_hit", lookup_hit, 0);
        check("t3_after_data", lookup_data, 0);
        waitEmpty(ec);

        // Duplicate addresses: youngest wins, FIFO drain leaves the newer data.
        offer(14'h007, {4{16'd1}}, t0);
        offer(14'h007, {4{16'd2}}, t1);
        lookup_addr = 14'h007;
        #1;
        check("t4_dup_hit", lookup_hit, 1);
        check("t4_dup_data", lookup_data, {4{16'd2}});
        waitEmpty(ec);
        for (int k = 0; k < 4; k++) check("t4_mem_final", memAt(16'h001C + k), 16'd2);

        // Asynchronous reset in the middle of a drain.
        offer(14'h009, {$urandom, $urandom}, t0);
        waitUntil(t0 + 9);
        check("t5_pre_reset_write", mem_write, 1);
        #2 reset = 1'b1;
        modelReset();
        #1;
        check("t5_mem_write", mem_write, 0);
        check("t5_empty", empty, 1);
        check("t5_wb_ready", wb_ready, 1);
        step();
        step();
        reset = 1'b0;
        repeat (20) step();

        // Random traffic with a small address pool for snoop hits and duplicates.
        for (int k = 0; k < 300; k++) begin
            lookup_addr = 14'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 45) begin
                rd = {$urandom, $urandom};
                offer(14'($urandom_range(0, 7)), rd, t0);
            end else begin
                step();
            end
        end

        for (int k = 0; k < 300 && (expWrites.size() != 0 || !empty); k++) step();
        check("final_drained", expWrites.size(), 0);
        check("final_empty", empty, 1);
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Block-granular write-back buffer between the direct-mapped cache's eviction path and backing memory. It accepts dirty 4-word victim blocks from the cache in one cycle, so the cache refill is not serialised behind the write-back. It drains queued blocks to memory one word per cycle after a fixed access latency. Pending blocks can be snooped so a refill of a just-evicted line returns the buffered data, not stale memory.

## Interface
- `DEPTH`, 2: number of block entries; a power of two ≥ 2.
- `LATENCY`, 7: cycles from drain start to the first word write; matches the cache miss counter.
- `WORD_SIZE`, 16: data word width.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `wb_valid` in 1: the cache offers a victim block this cycle.
- `wb_ready` out 1: the buffer accepts the block. A transfer occurs when `wb_valid && wb_ready`.
- `wb_addr` in 14: block address (word address bits [15:2]).
- `wb_data` in 4×WORD_SIZE: block words; word i is in bits [16i+15:16i].
- `lookup_addr` in 14: block address presented for a snoop by a refill.
- `lookup_hit` out 1: combinational. Some valid entry matches `lookup_addr`.
- `lookup_data` out 4×WORD_SIZE: words of the youngest matching entry. 0 when there is no hit.
- `mem_write` out 1: write strobe to backing memory for one word.
- `mem_address` out WORD_SIZE: word address {head block addr, word_idx}.
- `mem_data` out WORD_SIZE: word being written.
- `empty` out 1: no valid entries and the drain FSM is IDLE.

## Operation
- Storage is a circular FIFO of DEPTH entries. Each entry holds a valid bit, a 14-bit address and four words.
- Pointers:
  - `head` and `tail` are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` is 0..DEPTH.
- Enqueue on handshake: write the entry at `tail`, set it valid, advance `tail`, increment `count`.
- `wb_ready = (count < DEPTH) || retire`, where `retire` means the FSM is in WRITE with `word_idx == 3`. This allows enqueue into a full buffer in the cycle the head retires.
- Drain FSM:
  - IDLE: if `count > 0`, go to WAIT and load `lat_cnt = LATENCY-1`.
  - WAIT: decrement `lat_cnt`. When `lat_cnt == 0`, go to WRITE with `word_idx = 0`.
  - WRITE: assert `mem_write` with head address and word `word_idx`, then increment `word_idx`. When `word_idx == 3`, retire the head: clear valid, advance `head`, decrement `count`. Then go to WAIT if further entries remain (`count > 1`, or an enqueue in the same cycle), otherwise IDLE.
- A head entry stays valid and snoopable until its retire edge.
- Snoop:
  - Compare `lookup_addr` against every valid entry.
  - Priority goes to the entry nearest `tail` (the youngest), so a duplicate address enqueued later wins.
  - Duplicate addresses are not coalesced; both are drained in FIFO order.
- A same-cycle enqueue and retire leaves `count` unchanged and moves both pointers.
- Reset mid-drain: the partially written block is lost. Memory keeps the words already written. No further strobes are issued.

## Timing
- Reset values:
  - `wb_ready` = 1, `empty` = 1.
  - `mem_write`, `mem_address`, `mem_data`, `lookup_hit`, `lookup_data` = 0.
  - FSM in IDLE; `head`, `tail`, `count`, `word_idx`, `lat_cnt` = 0; all entries invalid.
- Enqueue at edge t into an empty buffer:
  - IDLE→WAIT at t+1.
  - First `mem_write` in cycle t+1+LATENCY.
  - Last word in cycle t+LATENCY+4.
  - `empty` = 1 after edge t+LATENCY+5.
- Back-to-back blocks: each block occupies LATENCY+4 cycles (LATENCY in WAIT, 4 in WRITE), with no IDLE cycle between blocks.
- `mem_*` outputs are registered from FSM state. They are valid the whole cycle and are 0 outside WRITE.
- `lookup_*` is purely combinational from stored state and `lookup_addr`. It reflects an enqueue only after that enqueue's edge.

## Structure
- The shared package holds:
  - `WORD_SIZE`, `BLOCK_WORDS = 4`.
  - The block address width of 14.
  - A `wb_entry_t` struct (valid, addr, data[4]).
  - A drain-state enum {IDLE, WAIT, WRITE}.
- One natural sub-module, `wb_drain_fsm`. It holds the state, `lat_cnt` and `word_idx`, and produces the `retire` and `mem_*` strobes. FIFO storage and snoop compare stay in the top.

## Test plan
- Reset, then enqueue addr 0x00A with words {1,2,3,4} at cycle 0. Required: writes to 0x0028..0x002B with data 1..4 in cycles 8..11, and `empty` = 1 from cycle 12.
- Fill DEPTH=2 (addrs 0x001, 0x002). Required: `wb_ready` = 0. Present a third block (0x003). Required: accepted exactly in the cycle of 0x001's word 3 write, and the drain order is 0x001, 0x002, 0x003.
- Enqueue 0x005 {A,B,C,D}, then snoop 0x005 during WAIT and during WRITE word 2. Required: hit with {A,B,C,D} both times. Required: miss after the retire edge.
- Enqueue 0x007 twice, first with {1,1,1,1}, then {2,2,2,2}. Required: a snoop returns {2,2,2,2}. Required: memory ends holding 2s after both drains.
- Assert `reset` asynchronously in cycle 9 of a drain. Required: `mem_write` drops immediately, `empty` = 1, `wb_ready` = 1, and no later writes occur.
- Hold `wb_valid` with `wb_ready` = 0 for 20 cycles. Required: no entry is overwritten, and `count` never exceeds DEPTH.
